// File: rtl/counter_buffer_ctrl.sv
// Write-port-A sequencer for the counter SRAM: arm, trigger, then store each valid
// count at the next address, stopping after N samples or wrapping in ring mode.
module counter_buffer_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 18,
  parameter int DEPTH      = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_arm,
  input  logic                  i_abort,
  input  logic                  i_trigger,
  input  logic                  i_continuous,
  input  logic [ADDR_WIDTH:0]   i_num_samples,
  input  logic                  i_count_valid,
  input  logic [DATA_WIDTH-1:0] i_count_data,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic                  o_sram_we,
  output logic [DATA_WIDTH-1:0] o_sram_data,
  output logic [1:0]            o_state,
  output logic [ADDR_WIDTH-1:0] o_write_ptr,
  output logic [ADDR_WIDTH:0]   o_fill,
  output logic                  o_wrapped,
  output logic                  o_irq
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t              state;
  logic                continuous;
  logic [ADDR_WIDTH:0] n_samples;

  logic accept;
  logic at_wrap;
  logic last_sample;

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latches.
  always_comb begin
    accept      = i_count_valid && !i_abort &&
                  ((state == RUN) || ((state == ARMED) && i_trigger));
    at_wrap     = (o_write_ptr == LAST_ADDR);
    last_sample = !continuous && (o_fill == (n_samples - (ADDR_WIDTH+1)'(1)));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values and later assignments in the block take priority.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= IDLE;
      continuous  <= 1'b0;
      n_samples   <= '0;
      o_sram_addr <= '0;
      o_sram_we   <= 1'b0;
      o_sram_data <= '0;
      o_write_ptr <= '0;
      o_fill      <= '0;
      o_wrapped   <= 1'b0;
      o_irq       <= 1'b0;
    end else begin
      o_sram_we <= 1'b0;
      o_irq     <= 1'b0;

      if (i_abort) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE, DONE: begin
            if (i_arm) begin
              continuous  <= i_continuous;
              n_samples   <= (i_num_samples == '0 || i_num_samples > DEPTH_W)
                             ? DEPTH_W : i_num_samples;
              o_write_ptr <= '0;
              o_fill      <= '0;
              o_wrapped   <= 1'b0;
              state       <= ARMED;
            end
          end
          ARMED:   if (i_trigger) state <= RUN;
          RUN:     ;
          default: state <= IDLE;
        endcase
      end

      // A sample taken in the trigger cycle lands here too; a DONE transition
      // below overrides the ARMED->RUN move above for N = 1.
      if (accept) begin
        o_sram_we   <= 1'b1;
        o_sram_addr <= o_write_ptr;
        o_sram_data <= i_count_data;
        o_write_ptr <= at_wrap ? '0 : o_write_ptr + ADDR_WIDTH'(1);
        if (o_fill != DEPTH_W) o_fill <= o_fill + (ADDR_WIDTH+1)'(1);
        if (at_wrap) o_wrapped <= 1'b1;
        if (last_sample) begin
          state <= DONE;
          o_irq <= 1'b1;
        end else if (continuous && at_wrap) begin
          o_irq <= 1'b1;
        end
      end
    end
  end

  assign o_state = state;

endmodule
